regfile_sb: RTL and testbench
=============================

# regfile_sb

- Parametrised register file with a per-register scoreboard, an N-read/1-write port structure, write-to-read bypass, and a post-reset zeroing sweep.
- Successor to the fixed 32x32, 2-read register file in the RISC-V core.
- Sits between decode (reads and reservations) and writeback (writes that clear reservations).
- The pipeline uses it to stall on RAW hazards without a separate scoreboard block.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of registers; power of two, at least 2; AW = $clog2(NREG) is derived
- NRP, 2, number of read ports, 1 to 4

Ports:
- clk  in  1  the single clock
- rst  in  1  reset, synchronous and active-high
- ready  out  1  high once the zeroing sweep is complete
- rd_addr  in  NRP*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd_data  out  NRP*XLEN  read data, per port
- rd_busy  out  NRP  reservation pending on the addressed register, per port
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback register
- wr_data  in  XLEN  writeback data
- rsv_en  in  1  reserve strobe; sets the busy bit for a register in flight
- rsv_addr  in  AW  register to reserve
- flush  in  1  clear all busy bits (pipeline flush)

## Operation
- States are INIT and RUN.
- rst=1: state becomes INIT, sweep counter becomes 0, all busy bits become 0. Outputs during reset: ready=0, rd_data=0, rd_busy=0.
- INIT: each cycle writes 0 to reg[cnt] and increments cnt. After reg[NREG-1] is written, the next state is RUN and ready=1.
  - The sweep takes exactly NREG cycles after rst deasserts.
  - In INIT, wr_en, rsv_en and flush are ignored; rd_data=0 and rd_busy=0 on all ports.
- RUN, write: when wr_en=1 and wr_addr!=0, reg[wr_addr]<=wr_data and busy[wr_addr]<=0.
- RUN, reserve: when rsv_en=1 and rsv_addr!=0, busy[rsv_addr]<=1.
- RUN, flush: flush=1 clears every busy bit. A reservation in the same cycle is dropped. A write in the same cycle is still performed.
- Register 0 is hardwired: it reads 0, is never busy, and writes or reservations to it are ignored.
- Reservation and write to the same register in the same cycle: the data is written and the busy bit ends up 1, so the new reservation wins.
- Read, port i (combinational):
  - addr==0: data 0, busy 0.
  - Otherwise, if wr_en and wr_addr==addr (RUN only): data is wr_data (bypass) and busy is 0.
  - Otherwise: data is reg[addr] and busy is busy[addr].
- All ports see identical results for identical addresses.
- rst asserted mid-operation: in-flight reservations are lost, state returns to INIT, and the sweep restarts from 0.

## Timing
- Read latency is 0 cycles: rd_data and rd_busy are combinational from rd_addr, the register state and the write port.
- Write: visible in the same cycle through the bypass and stored at the next clk edge.
- Reservation: takes effect at the clk edge. rd_busy reflects it from the following cycle. There is no same-cycle reserve bypass.
- Flush: takes effect at the clk edge. Busy bits read 0 from the following cycle.
- ready rises at the edge ending the last INIT cycle and stays high until rst.
- There are no back-pressure outputs. Every strobe is accepted in RUN.

## Structure
- Shared package regfile_pkg holds:
  - the state typedef rf_state_e {RF_INIT, RF_RUN}
  - default constants RF_XLEN=32 and RF_NREG=32
  - an address-width helper function
- Sub-module regfile_rdport holds one read port: the address-0 check, the bypass compare, the data mux and the busy mux. It is instantiated NRP times by a generate loop.
- The top level holds the storage array, the busy vector, the sweep counter and the FSM.

## Test plan
- Reset and sweep:
  - Hold rst for 3 cycles, then release. ready must be 0 for exactly 32 cycles, then 1.
  - During the sweep, rd_data=0 and rd_busy=0, and wr_en=1 to x5 with 0xDEAD_BEEF is ignored. After ready, x5 reads 0.
- Write/read with bypass:
  - In RUN, wr_en=1, x7=0x1234_5678, with rd_addr[0]=7 in the same cycle: rd_data[0]=0x1234_5678 in that cycle, and it persists next cycle with wr_en=0.
  - Writing x0=0xFFFF_FFFF leaves x0 reading 0 on every port.
- Scoreboard:
  - rsv x3, then read x3 next cycle: rd_busy=1.
  - Writeback x3=0xA5: in that cycle rd_busy=0 and rd_data=0xA5, and afterwards busy stays 0.
  - rsv x0 gives rd_busy=0.
- Simultaneous events:
  - rsv and wr to x9 in the same cycle: the next cycle gives rd_busy=1 and data equal to the written value.
  - flush with rsv x4, x6 already busy: next cycle x4 and x6 both have busy=0.
- Reset mid-operation:
  - Reserve x2, x8 and write x8=0x55, then pulse rst at sweep-complete+10.
  - ready drops, busy bits clear, the sweep restarts, and x8 reads 0 after ready.
  - Repeat with NRP=4, NREG=16, XLEN=64: ready after 16 cycles, and all four ports agree.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
// The address-width helper keeps the derived AW consistent across files.
package regfile_pkg;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

    localparam int RF_XLEN = 32;
    localparam int RF_NREG = 32;

    // Clamped to 1 so that a degenerate register count still yields a legal vector width.
    function automatic int rf_addr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: handles the x0 alias, the write bypass and the busy lookup.
// Returns zeros whenever the file is not in RUN, so that callers never see sweep residue.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int AW   = 5
) (
    input  logic            run_i,
    input  logic [AW-1:0]   addr_i,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    input  logic [XLEN-1:0] reg_data_i,
    input  logic            reg_busy_i,
    output logic [XLEN-1:0] data_o,
    output logic            busy_o
);

    always_comb begin
        data_o = '0;
        busy_o = 1'b0;
        if (run_i && (addr_i != '0)) begin
            // The writeback both supplies the data and retires the reservation.
            if (wr_en_i && (wr_addr_i == addr_i)) begin
                data_o = wr_data_i;
                busy_o = 1'b0;
            end else begin
                data_o = reg_data_i;
                busy_o = reg_busy_i;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// N-read / 1-write register file with per-register busy bits for RAW stalls.
// After reset it sweeps zeros into every entry before reporting ready.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN = RF_XLEN,
    parameter  int NREG = RF_NREG,
    parameter  int NRP  = 2,
    localparam int AW   = rf_addr_w(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                flush
);

    rf_state_e       state_q;
    logic [AW-1:0]   cnt_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            ready_q;
    logic            run;

    logic [XLEN-1:0] mem_q [NREG];
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    // Reset is synchronous, so the registered state still says RUN during the
    // first reset cycle; gating with rst keeps outputs quiet from that cycle on.
    assign run   = (state_q == RF_RUN) && !rst;
    assign ready = ready_q && !rst;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (!rst) begin
            if (state_q == RF_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
            end else if (wr_en && (wr_addr != '0)) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Ordering matters: writeback clears, flush clears all, and a surviving
    // reservation is applied last so it beats a same-register writeback.
    always_comb begin
        busy_d = busy_q;
        if (wr_en && (wr_addr != '0)) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (flush) begin
            busy_d = '0;
        end else if (rsv_en && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
            busy_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                RF_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == AW'(NREG - 1)) begin
                        state_q <= RF_RUN;
                        ready_q <= 1'b1;
                    end
                end
                RF_RUN: begin
                    busy_q <= busy_d;
                end
                default: begin
                    state_q <= RF_INIT;
                    cnt_q   <= '0;
                    busy_q  <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NRP; gi++) begin : g_rdport
        regfile_rdport #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_rdport (
            .run_i      (run),
            .addr_i     (rd_addr[gi*AW +: AW]),
            .wr_en_i    (wr_en),
            .wr_addr_i  (wr_addr),
            .wr_data_i  (wr_data),
            .reg_data_i (mem_q[rd_addr[gi*AW +: AW]]),
            .reg_busy_i (busy_q[rd_addr[gi*AW +: AW]]),
            .data_o     (rd_data[gi*XLEN +: XLEN]),
            .busy_o     (rd_busy[gi])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a default 32x32/2-port instance and a 16x64/4-port instance.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (XLEN=32, NREG=32, NRP=2, AW=5)
    logic        rst_a, ready_a, wr_en_a, rsv_en_a, flush_a;
    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic [1:0]  rd_busy_a;
    logic [4:0]  wr_addr_a, rsv_addr_a;
    logic [31:0] wr_data_a;

    // Instance B: XLEN=64, NREG=16, NRP=4, AW=4
    logic         rst_b, ready_b, wr_en_b, rsv_en_b, flush_b;
    logic [15:0]  rd_addr_b;
    logic [255:0] rd_data_b;
    logic [3:0]   rd_busy_b;
    logic [3:0]   wr_addr_b, rsv_addr_b;
    logic [63:0]  wr_data_b;

    int tests = 0;
    int fails = 0;

    regfile_sb u_a (
        .clk(clk), .rst(rst_a), .ready(ready_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .rsv_en(rsv_en_a), .rsv_addr(rsv_addr_a), .flush(flush_a)
    );

    regfile_sb #(.XLEN(64), .NREG(16), .NRP(4)) u_b (
        .clk(clk), .rst(rst_b), .ready(ready_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .rsv_en(rsv_en_b), .rsv_addr(rsv_addr_b), .flush(flush_b)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_a = 1'b1; wr_en_a = 1'b0; rsv_en_a = 1'b0; flush_a = 1'b0;
        rd_addr_a = '0; wr_addr_a = '0; rsv_addr_a = '0; wr_data_a = '0;
        rst_b = 1'b1; wr_en_b = 1'b0; rsv_en_b = 1'b0; flush_b = 1'b0;
        rd_addr_b = '0; wr_addr_b = '0; rsv_addr_b = '0; wr_data_b = '0;

        // ---------------- reset held 3 cycles ----------------
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ready", 256'(ready_a), 256'(0));
            check("rst_busy",  256'(rd_busy_a), 256'(0));
        end

        // ---------------- sweep: 32 cycles with a write attempt to x5 ----------------
        rst_a = 1'b0;
        wr_en_a = 1'b1; wr_addr_a = 5'd5; wr_data_a = 32'hDEAD_BEEF;
        rd_addr_a = {5'd5, 5'd5};
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k < 32) begin
                settle();
                check($sformatf("sweep_ready_%0d", k), 256'(ready_a), 256'(0));
                check($sformatf("sweep_data_%0d", k), 256'(rd_data_a), 256'(0));
                check($sformatf("sweep_busy_%0d", k), 256'(rd_busy_a), 256'(0));
            end
        end
        wr_en_a = 1'b0;
        settle();
        check("ready_after_32", 256'(ready_a), 256'(1));
        check("x5_after_sweep", 256'(rd_data_a), 256'(0));

        // ---------------- write with bypass ----------------
        wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'h1234_5678;
        rd_addr_a = {5'd5, 5'd7};
        settle();
        check("bypass_x7", 256'(rd_data_a[31:0]), 256'(32'h1234_5678));
        check("bypass_p1_x5", 256'(rd_data_a[63:32]), 256'(0));
        tick();
        wr_en_a = 1'b0;
        settle();
        check("stored_x7", 256'(rd_data_a[31:0]), 256'(32'h1234_5678));

        // x0 is hardwired
        wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'hFFFF_FFFF;
        rd_addr_a = {5'd0, 5'd0};
        settle();
        check("x0_bypass", 256'(rd_data_a), 256'(0));
        tick();
        wr_en_a = 1'b0;
        settle();
        check("x0_stored", 256'(rd_data_a), 256'(0));

        // ---------------- scoreboard ----------------
        rsv_en_a = 1'b1; rsv_addr_a = 5'd3; rd_addr_a = {5'd0, 5'd3};
        settle();
        check("rsv_same_cycle", 256'(rd_busy_a), 256'(0));
        tick();
        rsv_en_a = 1'b0;
        settle();
        check("rsv_x3_busy", 256'(rd_busy_a), 256'(2'b01));
        wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'h0000_00A5;
        settle();
        check("wb_x3_busy", 256'(rd_busy_a), 256'(0));
        check("wb_x3_data", 256'(rd_data_a[31:0]), 256'(32'hA5));
        tick();
        wr_en_a = 1'b0;
        settle();
        check("after_wb_busy", 256'(rd_busy_a), 256'(0));
        check("after_wb_data", 256'(rd_data_a[31:0]), 256'(32'hA5));
        rsv_en_a = 1'b1; rsv_addr_a = 5'd0;
        tick();
        rsv_en_a = 1'b0; rd_addr_a = {5'd0, 5'd0};
        settle();
        check("rsv_x0_busy", 256'(rd_busy_a), 256'(0));

        // ---------------- simultaneous reserve + write ----------------
        rsv_en_a = 1'b1; rsv_addr_a = 5'd9;
        wr_en_a = 1'b1; wr_addr_a = 5'd9; wr_data_a = 32'hCAFE_0009;
        tick();
        rsv_en_a = 1'b0; wr_en_a = 1'b0; rd_addr_a = {5'd9, 5'd9};
        settle();
        check("rsv_wr_x9_busy", 256'(rd_busy_a), 256'(2'b11));
        check("rsv_wr_x9_data", 256'(rd_data_a), 256'({32'hCAFE_0009, 32'hCAFE_0009}));

        // ---------------- flush beats a same-cycle reservation ----------------
        rsv_en_a = 1'b1; rsv_addr_a = 5'd4;
        tick();
        rsv_addr_a = 5'd6;
        tick();
        rsv_en_a = 1'b0; rd_addr_a = {5'd6, 5'd4};
        settle();
        check("x4_x6_busy", 256'(rd_busy_a), 256'(2'b11));
        flush_a = 1'b1; rsv_en_a = 1'b1; rsv_addr_a = 5'd10;
        tick();
        flush_a = 1'b0; rsv_en_a = 1'b0;
        settle();
        check("flush_x4_x6", 256'(rd_busy_a), 256'(0));
        rd_addr_a = {5'd9, 5'd10};
        settle();
        check("flush_x10_x9", 256'(rd_busy_a), 256'(0));

        // ---------------- reset mid-operation ----------------
        wr_en_a = 1'b1; wr_addr_a = 5'd8; wr_data_a = 32'h0000_0055;
        tick();
        wr_en_a = 1'b0; rsv_en_a = 1'b1; rsv_addr_a = 5'd2;
        tick();
        rsv_addr_a = 5'd8;
        tick();
        rsv_en_a = 1'b0; rd_addr_a = {5'd8, 5'd2};
        settle();
        check("pre_rst_busy", 256'(rd_busy_a), 256'(2'b11));
        check("pre_rst_x8", 256'(rd_data_a[63:32]), 256'(32'h55));
        rst_a = 1'b1;
        settle();
        check("mid_rst_ready", 256'(ready_a), 256'(0));
        check("mid_rst_data", 256'(rd_data_a), 256'(0));
        tick();
        rst_a = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k < 32) begin
                settle();
                check($sformatf("resweep_ready_%0d", k), 256'(ready_a), 256'(0));
            end
        end
        settle();
        check("resweep_ready", 256'(ready_a), 256'(1));
        check("resweep_busy", 256'(rd_busy_a), 256'(0));
        check("resweep_x8", 256'(rd_data_a[63:32]), 256'(0));

        // ---------------- instance B: 16 x 64, 4 ports ----------------
        tick();
        rst_b = 1'b0;
        rd_addr_b = {4'd1, 4'd2, 4'd3, 4'd4};
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k < 16) begin
                settle();
                check($sformatf("b_sweep_ready_%0d", k), 256'(ready_b), 256'(0));
            end
        end
        settle();
        check("b_ready_after_16", 256'(ready_b), 256'(1));
        check("b_zero_after_sweep", rd_data_b, 256'(0));
        wr_en_b = 1'b1; wr_addr_b = 4'd5; wr_data_b = 64'h0123_4567_89AB_CDEF;
        rd_addr_b = {4'd5, 4'd5, 4'd5, 4'd5};
        settle();
        check("b_bypass_all", rd_data_b, {4{64'h0123_4567_89AB_CDEF}});
        tick();
        wr_en_b = 1'b0; rsv_en_b = 1'b1; rsv_addr_b = 4'd3;
        settle();
        check("b_stored_all", rd_data_b, {4{64'h0123_4567_89AB_CDEF}});
        tick();
        rsv_en_b = 1'b0; rd_addr_b = {4'd0, 4'd5, 4'd3, 4'd3};
        settle();
        check("b_busy_ports", 256'(rd_busy_b), 256'(4'b0011));
        check("b_data_ports", rd_data_b, {64'h0, 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
